// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for the load scoreboard hazard unit
package core_pkg;

  localparam int REG_ADDR_WIDTH       = 5;
  localparam int NUM_ARCH_REGS        = 2 ** REG_ADDR_WIDTH;
  localparam int MAX_OUTSTAND_DEFAULT = 4;

  typedef enum logic [1:0] {
    HZ_NONE = 2'd0,
    HZ_RAW  = 2'd1,
    HZ_WAW  = 2'd2,
    HZ_FULL = 2'd3
  } hz_cause_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// rtl/hazard_perf_counter.sv - saturating 32-bit event counter with enable
module hazard_perf_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] count_o
);

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (en_i && (count_o != 32'hFFFF_FFFF)) begin
      count_o <= count_o + 32'd1;
    end
  end

endmodule

// File: rtl/load_scoreboard_hazard_unit.sv
// rtl/load_scoreboard_hazard_unit.sv - ID-stage pending-load scoreboard and stall generator; HAZARD_PERF_CNT_EN adds perf counters
module load_scoreboard_hazard_unit
  import core_pkg::*;
#(
  parameter int NUM_RS       = 2,
  parameter int MAX_OUTSTAND = MAX_OUTSTAND_DEFAULT
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_RS*REG_ADDR_WIDTH-1:0] rs_addr_ID_i,
  input  logic [NUM_RS-1:0]                rs_used_ID_i,
  input  logic [REG_ADDR_WIDTH-1:0]        rd_addr_ID_i,
  input  logic                             RegWrite_ID_i,
  input  logic                             MemRead_ID_i,
  input  logic [REG_ADDR_WIDTH-1:0]        rd_addr_EX_i,
  input  logic                             MemRead_EX_i,
  input  logic                             valid_EX_i,
  input  logic                             flush_EX_i,
  input  logic                             load_done_i,
  input  logic [REG_ADDR_WIDTH-1:0]        load_done_rd_i,
  output logic                             stall_o,
  output hz_cause_t                        stall_cause_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]                      stall_cycles_o,
  output logic [31:0]                      raw_stalls_o,
`endif
  output logic [3:0]                       outstanding_o
);

  logic [NUM_ARCH_REGS-1:1] pending_q;
  logic [NUM_ARCH_REGS-1:1] pending_d;
  logic [3:0]               cnt_q;
  logic [4:0]               cnt_sum;
  logic [NUM_ARCH_REGS-1:0] live_vec;
  logic [NUM_ARCH_REGS-1:0] raw_vec;
  logic                     issue;
  logic                     retire;
  logic                     raw_hit;
  logic                     waw_hit;
  logic                     full_hit;

  assign issue  = valid_EX_i & MemRead_EX_i & ~flush_EX_i & (rd_addr_EX_i != '0);
  assign retire = load_done_i & (load_done_rd_i != '0);

  // Per-register liveness, next scoreboard; a same-cycle issue outranks a retire.
  always_comb begin
    live_vec  = '0;
    raw_vec   = '0;
    pending_d = pending_q;
    for (int r = 1; r < NUM_ARCH_REGS; r++) begin
      live_vec[r] = pending_q[r] | (issue & (rd_addr_EX_i == REG_ADDR_WIDTH'(r)));
      raw_vec[r]  = (pending_q[r] & ~(retire & (load_done_rd_i == REG_ADDR_WIDTH'(r))))
                  | (issue & (rd_addr_EX_i == REG_ADDR_WIDTH'(r)));
      if (issue && (rd_addr_EX_i == REG_ADDR_WIDTH'(r))) begin
        pending_d[r] = 1'b1;
      end else if (retire && (load_done_rd_i == REG_ADDR_WIDTH'(r))) begin
        pending_d[r] = 1'b0;
      end
    end
  end

  // Next in-flight count; an unmatched retire at zero holds the count at zero.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + {4'd0, issue};
    if (retire && (cnt_sum != 5'd0)) begin
      cnt_sum = cnt_sum - 5'd1;
    end
  end

  // Hazard detection and cause priority RAW > WAW > FULL.
  always_comb begin
    raw_hit = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      raw_hit = raw_hit | (rs_used_ID_i[k] & raw_vec[rs_addr_ID_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]]);
    end
    waw_hit  = RegWrite_ID_i & live_vec[rd_addr_ID_i];
    full_hit = MemRead_ID_i & (cnt_sum >= 5'(MAX_OUTSTAND));
    stall_o  = raw_hit | waw_hit | full_hit;
    if (raw_hit) begin
      stall_cause_o = HZ_RAW;
    end else if (waw_hit) begin
      stall_cause_o = HZ_WAW;
    end else if (full_hit) begin
      stall_cause_o = HZ_FULL;
    end else begin
      stall_cause_o = HZ_NONE;
    end
  end

  assign outstanding_o = cnt_q;

  // Scoreboard and in-flight counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_sum[3:0];
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (stall_o),
    .count_o (stall_cycles_o)
  );

  hazard_perf_counter u_raw_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (raw_hit),
    .count_o (raw_stalls_o)
  );

  // A retire with nothing in flight means the memory side broke protocol.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(retire && !issue && (cnt_q == 4'd0)));
    end
  end
`endif

endmodule
